// File: rtl/instr_fetch.sv
// instr_fetch: program sequencer that feeds DIN/Run of the 16-bit bus processor from a host-loaded program memory.
// Optional build macro FETCH_WATCHDOG_EN: halt with fault when EXEC waits WDOG_LIMIT cycles without Done.
module instr_fetch #(
  parameter int ADDR_W     = 5,
  parameter int WDOG_LIMIT = 7
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Done,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  output logic [15:0]       DIN,
  output logic              Run,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALTED} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   pc_next;
  logic [15:0]         mem [DEPTH];
  logic [15:0]         cur_word;
  logic                is_halt;
  logic                is_mvi;
  logic                loadable;

  assign cur_word = mem[pc];
  assign is_halt  = (cur_word[15:13] == OP_HALT);
  assign is_mvi   = (cur_word[15:13] == OP_MVI);
  assign loadable = (state == S_IDLE) || (state == S_HALTED);

  // NOTE: the program array has no reset; clearing it would turn it into a huge reset fan-out for no benefit.
  always_ff @(posedge Clock) begin
    if (prog_we && loadable) mem[prog_addr] <= prog_data;
  end

`ifdef FETCH_WATCHDOG_EN
  logic [2:0] wdog_cnt, wdog_cnt_next;
  logic       fault_q, fault_next;
  assign fault = fault_q;
`else
  // Limit only matters with the watchdog compiled in.
  logic [2:0] unused_wdog_limit;
  assign unused_wdog_limit = 3'(WDOG_LIMIT);
  assign fault = 1'b0;
`endif

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc;
`ifdef FETCH_WATCHDOG_EN
    wdog_cnt_next = wdog_cnt;
    fault_next    = fault_q;
`endif
    unique case (state)
      S_IDLE, S_HALTED: begin
        if (Start) begin
          state_next = S_FETCH;
          pc_next    = '0;
`ifdef FETCH_WATCHDOG_EN
          fault_next = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        if (is_halt) begin
          state_next = S_HALTED;
        end else begin
          state_next = S_EXEC;
          // MVI moves pc onto its immediate so EXEC presents it on DIN.
          if (is_mvi) pc_next = pc + ADDR_W'(1);
`ifdef FETCH_WATCHDOG_EN
          wdog_cnt_next = '0;
`endif
        end
      end
      S_EXEC: begin
        if (Done) begin
          state_next = S_FETCH;
          pc_next    = pc + ADDR_W'(1);
        end
`ifdef FETCH_WATCHDOG_EN
        else if (wdog_cnt == 3'(WDOG_LIMIT - 1)) begin
          state_next = S_HALTED;
          fault_next = 1'b1;
        end else begin
          wdog_cnt_next = wdog_cnt + 3'd1;
        end
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= S_IDLE;
      pc    <= '0;
`ifdef FETCH_WATCHDOG_EN
      wdog_cnt <= '0;
      fault_q  <= 1'b0;
`endif
    end else begin
      state <= state_next;
      pc    <= pc_next;
`ifdef FETCH_WATCHDOG_EN
      wdog_cnt <= wdog_cnt_next;
      fault_q  <= fault_next;
`endif
    end
  end

  assign busy   = (state == S_FETCH) || (state == S_EXEC);
  assign halted = (state == S_HALTED);
  assign Run    = ((state == S_FETCH) && !is_halt) || (state == S_EXEC);
  assign DIN    = busy ? cur_word : 16'h0000;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Program sequencer that sits directly upstream of the 16-bit bus processor and drives its DIN and Run inputs. It holds a small host-loadable program memory and a program counter. It presents one instruction word per processor instruction cycle, and advances to the immediate word for MVI. It tracks the processor's Done to step through the program until a HALT word is reached.

## Interface
Parameters:
- ADDR_W, 5: program memory address width; depth = 2**ADDR_W words of 16 bits.
- WDOG_LIMIT, 7: maximum EXEC cycles without Done before fault (used only with the watchdog compiled in).

Ports:
- Clock  in  1  single system clock; all state changes on the rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle pulse that begins execution from address 0.
- Done  in  1  processor Done (combinational in the processor, sampled here on the rising edge).
- prog_we  in  1  program memory write enable.
- prog_addr  in  ADDR_W  program memory write address.
- prog_data  in  16  program memory write data.
- DIN  out  16  instruction/immediate word to the processor.
- Run  out  1  processor Run.
- pc  out  ADDR_W  current program counter.
- busy  out  1  high in FETCH or EXEC.
- halted  out  1  high in HALTED.
- fault  out  1  watchdog fault flag.

## Operation
Word format:
- DIN[15:13] is the opcode: 000 MV, 001 MVI, 010 ADD, 011 SUB, 111 HALT (fetch-only; never issued to the processor).
- DIN[12:10] is X; DIN[9:7] is Y.
- An MVI word is followed by one immediate word.

Memory:
- Registers with no reset; contents are undefined until written.
- Written on the clock edge when prog_we=1, only in IDLE or HALTED; writes in FETCH/EXEC are ignored.

FSM states: IDLE, FETCH, EXEC, HALTED.
- IDLE / HALTED, Start=1: pc<=0, fault<=0, go to FETCH.
- FETCH, mem[pc] opcode = HALT: go to HALTED; pc holds the HALT address.
- FETCH, any other opcode: go to EXEC. If the opcode is MVI, pc<=pc+1; otherwise pc is unchanged.
- EXEC, Done=1: pc<=pc+1, go to FETCH.
- EXEC, Done=0: stay in EXEC.
- Done is ignored outside EXEC.
- Start is ignored in FETCH and EXEC.

Outputs by state:
- Run=1 in FETCH (when opcode ≠ HALT) and in EXEC. Run=0 in IDLE, in HALTED, and in FETCH when mem[pc] is HALT.
- DIN=mem[pc] (combinational read) in FETCH and EXEC; DIN=16'h0000 otherwise. In EXEC after MVI, DIN therefore shows the immediate word.

Counter rules:
- pc arithmetic is modulo 2**ADDR_W; it wraps from the last address to 0.
- An MVI located at the last address takes its immediate from address 0.

Reset:
- Resetn low at any time, including mid-instruction, forces IDLE immediately.
- Reset values: pc=0, Run=0, DIN=0, busy=0, halted=0, fault=0.

## Timing
- Start sampled at edge E: FETCH in the cycle after E. The processor is in T0 during FETCH and loads IR at the edge ending FETCH.
- EXEC length follows the processor:
  - MV/MVI: 1 cycle (Done in T1).
  - ADD/SUB: 3 cycles (Done in T3).
- The cycle after Done is FETCH of the next word, with no bubble.
- Instruction throughput:
  - MV and MVI: 2 cycles each (MVI still occupies 2 words of memory).
  - ADD and SUB: 4 cycles each.
- HALT is detected combinationally in its FETCH cycle, so Run is never asserted for a HALT word.

## Configuration
FETCH_WATCHDOG_EN.
- Defined: a 3-bit counter clears on entry to EXEC and increments each EXEC cycle with Done=0. When it reaches WDOG_LIMIT without Done, the next state is HALTED with fault<=1 and Run=0. fault clears on Start or reset.
- Undefined: no counter; fault is tied to 0 and EXEC waits for Done indefinitely.

## Test plan
- Load 0:16'h2000, 1:16'h0005, 2:16'h0400, 3:16'h4080, 4:16'hE000 with the processor attached, then pulse Start. Required: R0=5, R1=5, then R0=10. halted=1 with pc=4, and Run=0 from that point.
- MVI placed at address 31 with the immediate at address 0. Required: DIN=mem[0] during EXEC, and the next FETCH is at pc=1.
- prog_we=1 while busy. Required: memory is unchanged. Start while busy: no effect on pc or state.
- Resetn pulsed low during the EXEC of an ADD. Required: IDLE, Run=0, pc=0 immediately. A subsequent Start restarts from address 0.
- With FETCH_WATCHDOG_EN defined, hold Done=0 after FETCH of 16'h4080. Required: fault=1 and halted=1 after 7 EXEC cycles. Start then clears fault.
- HALT at address 0. Required: after Start, one FETCH cycle with Run=0, then halted=1 and pc=0.
